// File: rtl/trans_allocator_ipa_if.sv
// -----------------------------------------------------------------------------
// trans_allocator_ipa_if
// Bundles the allocation, release, synch-unit status and status/event signals
// of the transfer-ID allocator.
//   master : core/software side (drives requests and synch-unit inputs)
//   slave  : allocator side
// Signals:
//   alloc_req_i / alloc_core_i        allocation request and requesting core
//   alloc_gnt_o / alloc_sid_o         same-cycle grant and granted SID
//   free_req_i / free_sid_i           release request and SID to release
//   trans_status_i / term_sig_i       per-ID busy and completion pulse
//   busy_o / pending_o / full_o       per-ID allocated / active, none free
//   event_o / err_o                   per-core termination event, illegal free
// -----------------------------------------------------------------------------
interface trans_allocator_ipa_if #(
   parameter int NB_TRANSFERS    = 4,
   parameter int TRANS_SID_WIDTH = 2,
   parameter int NB_CORES        = 4,
   parameter int CORE_ID_WIDTH   = 2
);
   logic                       alloc_req_i;
   logic [CORE_ID_WIDTH-1:0]   alloc_core_i;
   logic                       alloc_gnt_o;
   logic [TRANS_SID_WIDTH-1:0] alloc_sid_o;
   logic                       free_req_i;
   logic [TRANS_SID_WIDTH-1:0] free_sid_i;
   logic [NB_TRANSFERS-1:0]    trans_status_i;
   logic [NB_TRANSFERS-1:0]    term_sig_i;
   logic [NB_TRANSFERS-1:0]    busy_o;
   logic [NB_TRANSFERS-1:0]    pending_o;
   logic                       full_o;
   logic [NB_CORES-1:0]        event_o;
   logic                       err_o;

   modport master (
      output alloc_req_i, alloc_core_i, free_req_i, free_sid_i,
             trans_status_i, term_sig_i,
      input  alloc_gnt_o, alloc_sid_o, busy_o, pending_o, full_o,
             event_o, err_o
   );

   modport slave (
      input  alloc_req_i, alloc_core_i, free_req_i, free_sid_i,
             trans_status_i, term_sig_i,
      output alloc_gnt_o, alloc_sid_o, busy_o, pending_o, full_o,
             event_o, err_o
   );
endinterface : trans_allocator_ipa_if

// File: rtl/trans_allocator_ipa.sv
// -----------------------------------------------------------------------------
// trans_allocator_ipa
// Transfer-ID manager downstream of the per-ID synch units. Hands out the
// lowest free SID on a same-cycle req/gnt handshake, tracks each ID through
// FREE -> ALLOC -> ACTIVE -> DONE, raises a one-cycle event to the owning core
// when the ID's transfer terminates, and releases an ID only on an explicit
// free request. Illegal frees (ID in FREE/ACTIVE, or out-of-range SID) leave
// state untouched and pulse err_o one cycle later.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   bus_if  trans_allocator_ipa_if.slave (see interface file for signals)
// -----------------------------------------------------------------------------
module trans_allocator_ipa #(
   parameter int NB_TRANSFERS    = 4,
   parameter int TRANS_SID_WIDTH = 2,
   parameter int NB_CORES        = 4,
   parameter int CORE_ID_WIDTH   = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   trans_allocator_ipa_if.slave  bus_if
);

   typedef enum logic [1:0] {
      ST_FREE   = 2'b00,
      ST_ALLOC  = 2'b01,
      ST_ACTIVE = 2'b10,
      ST_DONE   = 2'b11
   } state_e;

   state_e                     state_q [NB_TRANSFERS];
   state_e                     state_d [NB_TRANSFERS];
   logic [CORE_ID_WIDTH-1:0]   owner_q [NB_TRANSFERS];
   logic [CORE_ID_WIDTH-1:0]   owner_d [NB_TRANSFERS];
   logic [NB_CORES-1:0]        event_q;
   logic [NB_CORES-1:0]        event_d;
   logic                       err_q;
   logic                       err_d;

   logic [NB_TRANSFERS-1:0]    free_vec_s;
   logic [NB_TRANSFERS-1:0]    pending_s;
   logic [NB_TRANSFERS-1:0]    free_hit_s;
   logic [NB_TRANSFERS-1:0]    free_ok_s;
   logic [NB_TRANSFERS-1:0]    term_acc_s;
   logic [NB_TRANSFERS-1:0]    grant_vec_s;
   logic [TRANS_SID_WIDTH-1:0] first_free_s;
   logic                       full_s;
   logic                       gnt_s;

   // Per-ID flags decoded from registered state and this cycle's requests
   always_comb begin
      free_vec_s  = {NB_TRANSFERS{1'b0}};
      pending_s   = {NB_TRANSFERS{1'b0}};
      free_hit_s  = {NB_TRANSFERS{1'b0}};
      free_ok_s   = {NB_TRANSFERS{1'b0}};
      term_acc_s  = {NB_TRANSFERS{1'b0}};
      for (int i = 0; i < NB_TRANSFERS; i++) begin
         free_vec_s[i] = (state_q[i] == ST_FREE);
         pending_s[i]  = (state_q[i] == ST_ACTIVE);
         // Out-of-range SIDs match no index, so they end up illegal
         free_hit_s[i] = bus_if.free_req_i &&
                         (bus_if.free_sid_i == TRANS_SID_WIDTH'(i));
         free_ok_s[i]  = free_hit_s[i] &&
                         ((state_q[i] == ST_ALLOC) || (state_q[i] == ST_DONE));
         term_acc_s[i] = bus_if.term_sig_i[i] &&
                         ((state_q[i] == ST_ALLOC) || (state_q[i] == ST_ACTIVE));
      end
   end

   assign full_s = ~(|free_vec_s);
   assign gnt_s  = bus_if.alloc_req_i & ~full_s;

   // Lowest-index FREE ID: scanning downward leaves the lowest hit last
   always_comb begin
      first_free_s = {TRANS_SID_WIDTH{1'b0}};
      for (int i = NB_TRANSFERS - 1; i >= 0; i--) begin
         first_free_s = free_vec_s[i] ? TRANS_SID_WIDTH'(i) : first_free_s;
      end
   end

   // One-hot of the ID being granted this cycle
   always_comb begin
      grant_vec_s = {NB_TRANSFERS{1'b0}};
      for (int i = 0; i < NB_TRANSFERS; i++) begin
         grant_vec_s[i] = gnt_s && (first_free_s == TRANS_SID_WIDTH'(i));
      end
   end

   // Next-state, owner capture, event and error computation
   always_comb begin
      event_d = {NB_CORES{1'b0}};
      err_d   = bus_if.free_req_i & ~(|free_ok_s);
      for (int i = 0; i < NB_TRANSFERS; i++) begin
         state_d[i] = state_q[i];
         owner_d[i] = owner_q[i];
         case (state_q[i])
            ST_FREE: begin
               if (grant_vec_s[i]) begin
                  state_d[i] = ST_ALLOC;
                  owner_d[i] = bus_if.alloc_core_i;
               end else begin
                  state_d[i] = ST_FREE;
               end
            end
            ST_ALLOC: begin
               if (free_hit_s[i]) begin
                  state_d[i] = ST_FREE;
               end else if (bus_if.term_sig_i[i]) begin
                  state_d[i] = ST_DONE;
               end else if (bus_if.trans_status_i[i]) begin
                  state_d[i] = ST_ACTIVE;
               end else begin
                  state_d[i] = ST_ALLOC;
               end
            end
            ST_ACTIVE: begin
               if (bus_if.term_sig_i[i]) begin
                  state_d[i] = ST_DONE;
               end else begin
                  state_d[i] = ST_ACTIVE;
               end
            end
            ST_DONE: begin
               // Free beats a re-use of the ID in the same cycle
               if (free_hit_s[i]) begin
                  state_d[i] = ST_FREE;
               end else if (bus_if.trans_status_i[i]) begin
                  state_d[i] = ST_ACTIVE;
               end else begin
                  state_d[i] = ST_DONE;
               end
            end
            default: begin
               state_d[i] = ST_FREE;
            end
         endcase
         // Terms of several IDs owned by one core merge into one pulse
         for (int c = 0; c < NB_CORES; c++) begin
            event_d[c] = event_d[c] |
                         (term_acc_s[i] && (owner_q[i] == CORE_ID_WIDTH'(c)));
         end
      end
   end

   // State, owner and registered output flops
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NB_TRANSFERS; i++) begin
            state_q[i] <= ST_FREE;
            owner_q[i] <= {CORE_ID_WIDTH{1'b0}};
         end
         event_q <= {NB_CORES{1'b0}};
         err_q   <= 1'b0;
      end else begin
         for (int i = 0; i < NB_TRANSFERS; i++) begin
            state_q[i] <= state_d[i];
            owner_q[i] <= owner_d[i];
         end
         event_q <= event_d;
         err_q   <= err_d;
      end
   end

   assign bus_if.alloc_gnt_o = gnt_s;
   assign bus_if.alloc_sid_o = full_s ? {TRANS_SID_WIDTH{1'b0}} : first_free_s;
   assign bus_if.busy_o      = ~free_vec_s;
   assign bus_if.pending_o   = pending_s;
   assign bus_if.full_o      = full_s;
   assign bus_if.event_o     = event_q;
   assign bus_if.err_o       = err_q;

endmodule : trans_allocator_ipa

// File: tb/tb_trans_allocator_ipa.sv
// -----------------------------------------------------------------------------
// tb_trans_allocator_ipa
// Directed self-checking bench for trans_allocator_ipa. Inputs change 1 time
// unit after the rising edge; outputs are sampled 1-2 time units after it.
// -----------------------------------------------------------------------------
module tb_trans_allocator_ipa;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   trans_allocator_ipa_if #(
      .NB_TRANSFERS(4), .TRANS_SID_WIDTH(2), .NB_CORES(4), .CORE_ID_WIDTH(2)
   ) bus_if ();

   trans_allocator_ipa #(
      .NB_TRANSFERS(4), .TRANS_SID_WIDTH(2), .NB_CORES(4), .CORE_ID_WIDTH(2)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus_if (bus_if)
   );

   // Free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [31:0] act,
                            input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic alloc_once(input logic [1:0] core, input logic [1:0] exp_sid);
      bus_if.alloc_req_i  = 1'b1;
      bus_if.alloc_core_i = core;
      #1;
      check_val("alloc_gnt", 32'(bus_if.alloc_gnt_o), 32'd1);
      check_val("alloc_sid", 32'(bus_if.alloc_sid_o), 32'(exp_sid));
      tick();
      bus_if.alloc_req_i = 1'b0;
   endtask

   task automatic free_once(input logic [1:0] sid, input logic exp_err);
      bus_if.free_req_i = 1'b1;
      bus_if.free_sid_i = sid;
      tick();
      bus_if.free_req_i = 1'b0;
      check_val("free_err", 32'(bus_if.err_o), 32'(exp_err));
   endtask

   initial begin
      n_checks              = 0;
      n_fail                = 0;
      rst_n                 = 1'b0;
      bus_if.alloc_req_i    = 1'b0;
      bus_if.alloc_core_i   = 2'd0;
      bus_if.free_req_i     = 1'b0;
      bus_if.free_sid_i     = 2'd0;
      bus_if.trans_status_i = 4'b0000;
      bus_if.term_sig_i     = 4'b0000;

      // Reset state
      #2;
      check_val("rst_busy",    32'(bus_if.busy_o),      32'h0);
      check_val("rst_pending", 32'(bus_if.pending_o),   32'h0);
      check_val("rst_full",    32'(bus_if.full_o),      32'h0);
      check_val("rst_event",   32'(bus_if.event_o),     32'h0);
      check_val("rst_err",     32'(bus_if.err_o),       32'h0);
      check_val("rst_gnt",     32'(bus_if.alloc_gnt_o), 32'h0);
      tick();
      rst_n = 1'b1;
      tick();

      // Four allocations from core 2, then full
      for (int k = 0; k < 4; k++) alloc_once(2'd2, 2'(k));
      #1;
      check_val("full_set",  32'(bus_if.full_o), 32'd1);
      check_val("busy_all",  32'(bus_if.busy_o), 32'hf);
      bus_if.alloc_req_i = 1'b1;
      #1;
      check_val("full_nogrant", 32'(bus_if.alloc_gnt_o), 32'd0);
      check_val("full_sid0",    32'(bus_if.alloc_sid_o), 32'd0);
      bus_if.alloc_req_i = 1'b0;
      for (int k = 0; k < 4; k++) free_once(2'(k), 1'b0);
      check_val("busy_cleared", 32'(bus_if.busy_o), 32'h0);
      check_val("full_cleared", 32'(bus_if.full_o), 32'h0);

      // Full lifecycle of SID 0 owned by core 3
      alloc_once(2'd3, 2'd0);
      check_val("alloc_busy",    32'(bus_if.busy_o),    32'h1);
      check_val("alloc_pending", 32'(bus_if.pending_o), 32'h0);
      bus_if.trans_status_i = 4'b0001;
      for (int k = 0; k < 5; k++) begin
         tick();
         check_val("active_pending", 32'(bus_if.pending_o), 32'h1);
         check_val("active_event",   32'(bus_if.event_o),   32'h0);
      end
      bus_if.trans_status_i = 4'b0000;
      bus_if.term_sig_i     = 4'b0001;
      tick();
      bus_if.term_sig_i = 4'b0000;
      check_val("term_event",   32'(bus_if.event_o),   32'h8);
      check_val("done_pending", 32'(bus_if.pending_o), 32'h0);
      check_val("done_busy",    32'(bus_if.busy_o),    32'h1);
      tick();
      check_val("event_one_cycle", 32'(bus_if.event_o), 32'h0);
      check_val("done_busy_hold",  32'(bus_if.busy_o),  32'h1);
      free_once(2'd0, 1'b0);
      check_val("freed_busy", 32'(bus_if.busy_o), 32'h0);

      // Free and allocate in the same cycle while full
      for (int k = 0; k < 4; k++) alloc_once(2'd0, 2'(k));
      bus_if.free_req_i   = 1'b1;
      bus_if.free_sid_i   = 2'd1;
      bus_if.alloc_req_i  = 1'b1;
      bus_if.alloc_core_i = 2'd0;
      #1;
      check_val("samecyc_nogrant", 32'(bus_if.alloc_gnt_o), 32'd0);
      tick();
      bus_if.free_req_i = 1'b0;
      check_val("samecyc_err", 32'(bus_if.err_o), 32'd0);
      #1;
      check_val("nextcyc_grant", 32'(bus_if.alloc_gnt_o), 32'd1);
      check_val("nextcyc_sid",   32'(bus_if.alloc_sid_o), 32'd1);
      tick();
      bus_if.alloc_req_i = 1'b0;
      check_val("refull", 32'(bus_if.full_o), 32'd1);

      // Illegal frees
      bus_if.trans_status_i = 4'b0100;
      tick();
      bus_if.trans_status_i = 4'b0000;
      check_val("sid2_active", 32'(bus_if.pending_o), 32'h4);
      free_once(2'd2, 1'b1);
      check_val("illegal_busy_kept", 32'(bus_if.busy_o), 32'hf);
      tick();
      check_val("err_one_cycle", 32'(bus_if.err_o), 32'd0);
      free_once(2'd3, 1'b0);
      free_once(2'd3, 1'b1);
      bus_if.term_sig_i = 4'b0100;
      tick();
      bus_if.term_sig_i = 4'b0000;
      check_val("core0_event", 32'(bus_if.event_o), 32'h1);
      free_once(2'd2, 1'b0);
      free_once(2'd0, 1'b0);
      free_once(2'd1, 1'b0);
      check_val("all_free_again", 32'(bus_if.busy_o), 32'h0);

      // Two IDs of core 1 terminating together
      alloc_once(2'd1, 2'd0);
      alloc_once(2'd1, 2'd1);
      bus_if.trans_status_i = 4'b0011;
      tick();
      bus_if.trans_status_i = 4'b0000;
      check_val("dual_pending", 32'(bus_if.pending_o), 32'h3);
      bus_if.term_sig_i = 4'b0011;
      tick();
      bus_if.term_sig_i = 4'b0000;
      check_val("dual_event",   32'(bus_if.event_o),   32'h2);
      check_val("dual_done",    32'(bus_if.pending_o), 32'h0);
      check_val("dual_busy",    32'(bus_if.busy_o),    32'h3);
      bus_if.term_sig_i = 4'b0011;
      tick();
      bus_if.term_sig_i = 4'b0000;
      check_val("done_term_ignored", 32'(bus_if.event_o), 32'h0);
      free_once(2'd0, 1'b0);
      free_once(2'd1, 1'b0);

      // Reset while two IDs are active and an event is due
      alloc_once(2'd2, 2'd0);
      alloc_once(2'd2, 2'd1);
      bus_if.trans_status_i = 4'b0011;
      tick();
      bus_if.trans_status_i = 4'b0000;
      bus_if.term_sig_i     = 4'b0011;
      #1;
      rst_n = 1'b0;
      #1;
      check_val("midrst_busy",    32'(bus_if.busy_o),    32'h0);
      check_val("midrst_pending", 32'(bus_if.pending_o), 32'h0);
      check_val("midrst_event",   32'(bus_if.event_o),   32'h0);
      bus_if.term_sig_i = 4'b0000;
      tick();
      check_val("midrst_event_dropped", 32'(bus_if.event_o), 32'h0);
      rst_n = 1'b1;
      #1;
      bus_if.alloc_req_i  = 1'b1;
      bus_if.alloc_core_i = 2'd0;
      #1;
      check_val("postrst_gnt", 32'(bus_if.alloc_gnt_o), 32'd1);
      check_val("postrst_sid", 32'(bus_if.alloc_sid_o), 32'd0);
      tick();
      bus_if.alloc_req_i = 1'b0;
      check_val("postrst_busy", 32'(bus_if.busy_o), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_trans_allocator_ipa
